decode_issue: RTL and testbench

- Decode/issue stage that produces every control and operand input consumed by the 16-bit ALU: rs1/rs2 data, imm, imm_en, func4 and jalr_en.
- Accepts 16-bit instructions from fetch and decodes them.
- Reads an internal 8x16 register file that writeback updates.
- Tracks RAW/WAW hazards with a per-register busy scoreboard.
- Presents one registered issue packet to execute under a valid/ready handshake.

---
 rtl/decode_issue.sv | 165 ++++++++++++++++
 tb/tb_decode_issue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue.sv
// decode_issue: decodes 16-bit instructions, reads the register file, tracks
// busy registers and holds one registered issue packet for the ALU stage.
module decode_issue #(
    parameter int NREGS = 8,
    parameter int XLEN  = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [15:0]     instr_i,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  logic            wb_we_i,
    input  logic [2:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            flush_i,
    output logic            issue_valid_o,
    input  logic            issue_ready_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic [XLEN-1:0] imm_o,
    output logic            imm_en_o,
    output logic [3:0]      func4_o,
    output logic            jalr_en_o,
    output logic [2:0]      rd_o,
    output logic            rd_we_o,
    output logic            illegal_o
);

    logic [3:0]      op;
    logic [2:0]      rd, rs1, rs2, src1;
    logic [XLEN-1:0] d_imm;
    logic [3:0]      d_func4;
    logic            d_imm_en, d_jalr, d_we, d_rd_we;
    logic            use1, use2, legal;

    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] rs1_rd, rs2_rd;

    logic [NREGS-1:0] busy, busy_avail, busy_next;
    logic [NREGS-1:0] clr, fl_clr, set;
    logic             hazard, slot_free, accept;

    assign op  = instr_i[15:12];
    assign rd  = instr_i[11:9];
    assign rs1 = instr_i[8:6];
    assign rs2 = instr_i[5:3];

    always_comb begin
        d_imm    = '0;
        d_imm_en = 1'b0;
        d_func4  = 4'h0;
        d_jalr   = 1'b0;
        d_we     = 1'b0;
        use1     = 1'b0;
        use2     = 1'b0;
        src1     = rs1;
        legal    = 1'b1;
        unique case (op) inside
            [4'h0:4'h8]: begin
                d_func4 = op;
                d_we    = 1'b1;
                use1    = 1'b1;
                use2    = 1'b1;
            end
            4'h9: begin
                d_imm    = {{(XLEN-6){instr_i[5]}}, instr_i[5:0]};
                d_imm_en = 1'b1;
                d_we     = 1'b1;
                use1     = 1'b1;
            end
            4'hA: begin
                src1     = 3'd0;
                d_imm    = {{(XLEN-9){instr_i[8]}}, instr_i[8:0]};
                d_imm_en = 1'b1;
                d_we     = 1'b1;
            end
            4'hB: begin
                d_imm    = {{(XLEN-6){instr_i[5]}}, instr_i[5:0]};
                d_imm_en = 1'b1;
                d_jalr   = 1'b1;
                use1     = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    assign d_rd_we = d_we && (rd != 3'd0);

    // Reads see a same-cycle writeback so a stalled consumer can go on that edge.
    always_comb begin
        rs1_rd = '0;
        rs2_rd = '0;
        if (src1 != 3'd0)
            rs1_rd = (wb_we_i && wb_rd_i == src1) ? wb_data_i : regs[src1];
        if (rs2 != 3'd0)
            rs2_rd = (wb_we_i && wb_rd_i == rs2) ? wb_data_i : regs[rs2];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_we_i && wb_rd_i != 3'd0) begin
            regs[wb_rd_i] <= wb_data_i;
        end
    end

    always_comb begin
        clr    = '0;
        fl_clr = '0;
        set    = '0;
        if (wb_we_i) clr[wb_rd_i] = 1'b1;
        if (flush_i && issue_valid_o && rd_we_o) fl_clr[rd_o] = 1'b1;
        if (accept && legal && d_rd_we) set[rd] = 1'b1;
    end

    assign busy_avail = busy & ~clr;

    always_comb begin
        busy_next    = (busy & ~(clr | fl_clr)) | set;
        busy_next[0] = 1'b0;
    end

    assign hazard = legal && ((use1 && busy_avail[src1]) ||
                              (use2 && busy_avail[rs2]) ||
                              (d_rd_we && busy_avail[rd]));

    assign slot_free     = !issue_valid_o || issue_ready_i;
    assign instr_ready_o = !rst_i && slot_free && !hazard && !flush_i;
    assign accept        = instr_valid_i && instr_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy          <= '0;
            issue_valid_o <= 1'b0;
            rs1_data_o    <= '0;
            rs2_data_o    <= '0;
            imm_o         <= '0;
            imm_en_o      <= 1'b0;
            func4_o       <= 4'h0;
            jalr_en_o     <= 1'b0;
            rd_o          <= 3'd0;
            rd_we_o       <= 1'b0;
            illegal_o     <= 1'b0;
        end else begin
            busy      <= busy_next;
            illegal_o <= accept && !legal;
            if (flush_i) begin
                issue_valid_o <= 1'b0;
            end else if (accept && legal) begin
                issue_valid_o <= 1'b1;
                rs1_data_o    <= rs1_rd;
                rs2_data_o    <= rs2_rd;
                imm_o         <= d_imm;
                imm_en_o      <= d_imm_en;
                func4_o       <= d_func4;
                jalr_en_o     <= d_jalr;
                rd_o          <= rd;
                rd_we_o       <= d_rd_we;
            end else if (issue_ready_i) begin
                issue_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed scenarios then random traffic, each cycle checked
// against a behavioural model of the decode/issue rules.
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr_i = '0;
    logic        instr_valid_i = 1'b0;
    logic        instr_ready_o;
    logic        wb_we_i = 1'b0;
    logic [2:0]  wb_rd_i = '0;
    logic [15:0] wb_data_i = '0;
    logic        flush_i = 1'b0;
    logic        issue_valid_o;
    logic        issue_ready_i = 1'b0;
    logic [15:0] rs1_data_o, rs2_data_o, imm_o;
    logic        imm_en_o, jalr_en_o, rd_we_o, illegal_o;
    logic [3:0]  func4_o;
    logic [2:0]  rd_o;

    always #5 clk = ~clk;

    decode_issue dut (
        .clk_i(clk), .rst_i(rst),
        .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .instr_ready_o(instr_ready_o),
        .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .flush_i(flush_i),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
        .imm_o(imm_o), .imm_en_o(imm_en_o), .func4_o(func4_o),
        .jalr_en_o(jalr_en_o), .rd_o(rd_o), .rd_we_o(rd_we_o),
        .illegal_o(illegal_o)
    );

    int compared = 0;
    int mismatched = 0;

    // Model: architectural registers, pending-write set, one issue slot.
    logic [15:0] mregs [8];
    bit          mpend [8];
    bit          mv, mill;
    logic [15:0] m_rs1, m_rs2, m_imm;
    bit          m_immen, m_jalr, m_we, m_useb;
    logic [3:0]  m_func;
    logic [2:0]  m_rd;
    bit          last_ready;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sext(input int v, input int bits);
        int x;
        x = v;
        if (x >= (1 << (bits - 1))) x = x - (1 << bits);
        return 16'(x);
    endfunction

    function automatic logic [15:0] mread(input int a, input bit we,
                                          input int wrd, input logic [15:0] wd);
        if (a == 0) return 16'h0;
        if (we && wrd == a) return wd;
        return mregs[a];
    endfunction

    task automatic mreset();
        for (int i = 0; i < 8; i++) begin
            mregs[i] = '0;
            mpend[i] = 1'b0;
        end
        mv = 1'b0;
        mill = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, issue_valid_o, 0);
        chk({tag, "_ready"}, instr_ready_o, 0);
        chk({tag, "_illegal"}, illegal_o, 0);
        chk({tag, "_rs1"}, rs1_data_o, 0);
        chk({tag, "_rs2"}, rs2_data_o, 0);
        chk({tag, "_imm"}, imm_o, 0);
        chk({tag, "_ctl"}, {imm_en_o, jalr_en_o, rd_we_o, func4_o, rd_o}, 0);
    endtask

    // One clock: drive, check against the model, advance the model, take the edge.
    task automatic cyc(input logic [15:0] ins, input bit v, input bit rdy,
                       input bit we, input logic [2:0] wrd,
                       input logic [15:0] wd, input bit fl);
        int op, rd, rs1, rs2, srca;
        bit legal, usea, useb, writes, hazard, ready, accept;
        bit pa [8];
        logic [15:0] imm, ra, rb;
        instr_i = ins;
        instr_valid_i = v;
        issue_ready_i = rdy;
        wb_we_i = we;
        wb_rd_i = wrd;
        wb_data_i = wd;
        flush_i = fl;
        #3;
        op = int'(ins[15:12]);
        rd = int'(ins[11:9]);
        rs1 = int'(ins[8:6]);
        rs2 = int'(ins[5:3]);
        legal = op < 12;
        usea = op <= 9 || op == 11;
        useb = op <= 8;
        writes = op <= 10 && rd != 0;
        srca = (op == 10) ? 0 : rs1;
        if (op == 9 || op == 11) imm = sext(int'(ins[5:0]), 6);
        else if (op == 10) imm = sext(int'(ins[8:0]), 9);
        else imm = 16'h0;
        for (int i = 0; i < 8; i++) pa[i] = mpend[i] && !(we && int'(wrd) == i);
        hazard = legal && ((usea && pa[srca]) || (useb && pa[rs2]) ||
                           (writes && pa[rd]));
        ready = (!mv || rdy) && !fl && !hazard;
        accept = v && ready;
        ra = mread(srca, we, int'(wrd), wd);
        rb = mread(rs2, we, int'(wrd), wd);

        chk("instr_ready", instr_ready_o, ready);
        last_ready = instr_ready_o;
        chk("issue_valid", issue_valid_o, mv);
        chk("illegal", illegal_o, mill);
        if (mv) begin
            chk("rs1_data", rs1_data_o, m_rs1);
            if (m_useb) chk("rs2_data", rs2_data_o, m_rs2);
            chk("imm", imm_o, m_imm);
            chk("imm_en", imm_en_o, m_immen);
            chk("func4", func4_o, m_func);
            chk("jalr_en", jalr_en_o, m_jalr);
            chk("rd", rd_o, m_rd);
            chk("rd_we", rd_we_o, m_we);
        end

        if (we && wrd != 0) begin
            mregs[wrd] = wd;
            mpend[wrd] = 1'b0;
        end
        if (fl) begin
            if (mv && m_we) mpend[m_rd] = 1'b0;
            mv = 1'b0;
            mill = 1'b0;
        end else begin
            mill = accept && !legal;
            if (accept && legal) begin
                mv = 1'b1;
                m_rs1 = ra;
                m_rs2 = rb;
                m_useb = useb;
                m_imm = imm;
                m_immen = op >= 9;
                m_func = useb ? 4'(op) : 4'h0;
                m_jalr = op == 11;
                m_rd = 3'(rd);
                m_we = writes;
                if (writes) mpend[rd] = 1'b1;
            end else if (rdy) begin
                mv = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int q[$];
        int regs_left[4];
        logic [15:0] ins;
        logic [2:0] wrd;
        mreset();
        #2;
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        cyc({4'hA, 3'd1, 9'd5}, 1, 1, 0, 0, 0, 0);
        chk("li_imm", imm_o, 16'd5);
        cyc({4'h0, 3'd2, 3'd1, 3'd1, 3'd0}, 1, 1, 0, 0, 0, 0);
        chk("add_stall", last_ready, 0);
        cyc({4'h0, 3'd2, 3'd1, 3'd1, 3'd0}, 1, 1, 1, 3'd1, 16'd5, 0);
        chk("add_bypass_ready", last_ready, 1);
        chk("add_rs1", rs1_data_o, 16'd5);
        chk("add_rs2", rs2_data_o, 16'd5);
        chk("add_func4", func4_o, 0);

        cyc({4'h9, 3'd3, 3'd0, 6'h3F}, 1, 1, 0, 0, 0, 0);
        chk("addi_imm", imm_o, 16'hFFFF);
        chk("addi_imm_en", imm_en_o, 1);
        chk("addi_rd", rd_o, 3);
        chk("addi_rd_we", rd_we_o, 1);

        cyc(16'h0, 0, 1, 1, 3'd4, 16'h1235, 0);
        cyc({4'h6, 3'd5, 3'd4, 3'd4, 3'd0}, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc({4'h8, 3'd7, 3'd4, 3'd0, 3'd0}, 1, 0, 0, 0, 0, 0);
            chk("hold_ready", last_ready, 0);
            chk("hold_rd", rd_o, 5);
            chk("hold_func4", func4_o, 6);
        end
        cyc({4'h8, 3'd7, 3'd4, 3'd0, 3'd0}, 1, 1, 0, 0, 0, 0);
        chk("b2b_ready", last_ready, 1);
        chk("b2b_valid", issue_valid_o, 1);
        chk("b2b_func4", func4_o, 8);

        cyc({4'hB, 3'd1, 3'd4, 6'd2}, 1, 1, 0, 0, 0, 0);
        chk("jalr_en", jalr_en_o, 1);
        chk("jalr_rs1", rs1_data_o, 16'h1235);
        chk("jalr_imm", imm_o, 16'd2);
        chk("jalr_rd_we", rd_we_o, 0);

        cyc({4'hE, 12'h123}, 1, 1, 0, 0, 0, 0);
        chk("illegal_pulse", illegal_o, 1);
        chk("illegal_no_issue", issue_valid_o, 0);
        cyc(16'h0, 0, 1, 0, 0, 0, 0);
        chk("illegal_one_cycle", illegal_o, 0);

        regs_left = '{2, 3, 5, 7};
        foreach (regs_left[i])
            cyc(16'h0, 0, 1, 1, 3'(regs_left[i]), 16'(16'h1000 + i), 0);
        cyc({4'h0, 3'd0, 3'd4, 3'd4, 3'd0}, 1, 1, 0, 0, 0, 0);
        chk("rd0_rd_we", rd_we_o, 0);

        cyc({4'hA, 3'd6, 9'd7}, 1, 1, 0, 0, 0, 0);
        cyc(16'h0, 0, 0, 0, 0, 0, 0);
        cyc({4'h0, 3'd7, 3'd6, 3'd6, 3'd0}, 1, 0, 0, 0, 0, 1);
        chk("flush_ready", last_ready, 0);
        chk("flush_valid", issue_valid_o, 0);
        cyc({4'h0, 3'd7, 3'd6, 3'd6, 3'd0}, 1, 1, 0, 0, 0, 0);
        chk("after_flush_ready", last_ready, 1);
        chk("after_flush_rs1", rs1_data_o, 0);

        cyc({4'hA, 3'd1, 9'd3}, 1, 1, 0, 0, 0, 0);
        cyc(16'h0, 0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("mid_reset");
        mreset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int n = 0; n < 800; n++) begin
            ins = 16'($urandom);
            q.delete();
            for (int i = 1; i < 8; i++) if (mpend[i]) q.push_back(i);
            if (q.size() > 0 && $urandom_range(0, 1) == 1)
                wrd = 3'(q[$urandom_range(0, q.size() - 1)]);
            else
                wrd = 3'($urandom_range(0, 7));
            cyc(ins, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1, wrd, 16'($urandom),
                $urandom_range(0, 19) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
